// File: rtl/pc_pkg.sv
// Shared types for the program-counter generator.
//   pc_state_t : fetch control FSM states
//   next_sel_t : source selected for the next fetch address
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } pc_state_t;

    typedef enum logic [2:0] {
        SEL_TRAP  = 3'd0,
        SEL_REDIR = 3'd1,
        SEL_RAS   = 3'd2,
        SEL_SEQ   = 3'd3,
        SEL_HOLD  = 3'd4
    } next_sel_t;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer with a top pointer and an occupancy
// count. Pushing when full overwrites the oldest entry.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   push_i        : push push_addr_i (replaces top when combined with pop_i)
//   pop_i         : drop the top entry (ignored when empty)
//   clear_i       : empty the stack
//   push_addr_i   : return address to store
//   top_o         : current top-of-stack entry
//   empty_o       : stack holds no entries
module pc_ras
    import pc_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] push_addr_i,
    output logic [XLEN-1:0] top_o,
    output logic            empty_o
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

    logic [XLEN-1:0] stack_q [RAS_DEPTH];
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wr_en;
    logic [PW-1:0]   wr_idx;

    assign empty_o = (cnt_q == '0);
    assign top_o   = stack_q[ptr_q];

    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = ptr_q;
        if (clear_i) begin
            ptr_d = '0;
            cnt_d = '0;
        end else if (push_i && pop_i && !empty_o) begin
            // Call and return on the same fetch: swap the top in place.
            wr_en = 1'b1;
        end else if (push_i) begin
            // Also reached for push+pop on an empty stack: the pop is void.
            wr_en  = 1'b1;
            wr_idx = ptr_q + PW'(1);
            ptr_d  = wr_idx;
            if (cnt_q != DEPTH_C)
                cnt_d = cnt_q + CW'(1);
        end else if (pop_i && !empty_o) begin
            ptr_d = ptr_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Entry contents need no reset; only pointer and count are qualified.
    always_ff @(posedge clk) begin
        if (wr_en)
            stack_q[wr_idx] <= push_addr_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator. Arbitrates trap, redirect, RAS
// prediction and sequential advance, and presents the fetch address over a
// valid/ready handshake. All outputs are registered.
// Ports:
//   clk, rst                   : clock, asynchronous active-low reset
//   fetch_valid/ready/pc       : fetch request handshake and address
//   stall                      : hold sequential advance and RAS ops
//   redirect_valid/pc          : resolved branch/jump target
//   trap_valid/pc              : trap entry/return target
//   ras_push/ras_push_addr     : call decoded on current fetch
//   ras_pop                    : return decoded on current fetch
//   halt_req                   : debug halt request (level)
//   misaligned                 : pulse, rejected misaligned redirect
//   halted                     : FSM is in HALTED
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] START_ADDR = '0,
    parameter int              IALIGN     = 4,
    parameter int              RAS_DEPTH  = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            fetch_valid,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] fetch_pc,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            ras_push,
    input  logic [XLEN-1:0] ras_push_addr,
    input  logic            ras_pop,
    input  logic            halt_req,
    output logic            misaligned,
    output logic            halted
);

    localparam int              AW         = $clog2(IALIGN);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(IALIGN - 1));
    localparam logic [XLEN-1:0] STEP       = XLEN'(IALIGN);

    pc_state_t       state_q;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, halted_q, mis_q, mis_d;
    next_sel_t       sel;
    logic            fire, redir_mis, ras_ops, ras_empty;
    logic [XLEN-1:0] ras_top;

    assign fire      = valid_q & fetch_ready & ~stall;
    assign redir_mis = |redirect_pc[AW-1:0];
    // Trap/redirect in the same cycle squash the decoded call/return.
    assign ras_ops   = fire & ~trap_valid & ~redirect_valid;

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst         (rst),
        .push_i      (ras_ops & ras_push),
        .pop_i       (ras_ops & ras_pop),
        .clear_i     (trap_valid),
        .push_addr_i (ras_push_addr),
        .top_o       (ras_top),
        .empty_o     (ras_empty)
    );

    always_comb begin
        if (trap_valid)
            sel = SEL_TRAP;
        else if (redirect_valid && !redir_mis)
            sel = SEL_REDIR;
        else if (redirect_valid)
            sel = SEL_HOLD;
        else if (fire && ras_pop && !ras_empty)
            sel = SEL_RAS;
        else if (fire)
            sel = SEL_SEQ;
        else
            sel = SEL_HOLD;
    end

    always_comb begin
        pc_d = pc_q;
        case (sel)
            SEL_TRAP:  pc_d = trap_pc & ALIGN_MASK;
            SEL_REDIR: pc_d = redirect_pc;
            SEL_RAS:   pc_d = ras_top;
            SEL_SEQ:   pc_d = pc_q + STEP;
            default:   pc_d = pc_q;
        endcase
    end

    assign mis_d = redirect_valid & ~trap_valid & redir_mis;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= BOOT;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            pc_q     <= START_ADDR;
            mis_q    <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            mis_q <= mis_d;
            if (trap_valid) begin
                state_q  <= RUN;
                valid_q  <= 1'b1;
                halted_q <= 1'b0;
            end else begin
                case (state_q)
                    BOOT: begin
                        state_q  <= RUN;
                        valid_q  <= 1'b1;
                        halted_q <= 1'b0;
                    end
                    RUN: begin
                        if (halt_req && !redirect_valid) begin
                            state_q  <= HALTED;
                            valid_q  <= 1'b0;
                            halted_q <= 1'b1;
                        end
                    end
                    HALTED: begin
                        if (!halt_req) begin
                            state_q  <= RUN;
                            valid_q  <= 1'b1;
                            halted_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q  <= BOOT;
                        valid_q  <= 1'b0;
                        halted_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign fetch_valid = valid_q;
    assign fetch_pc    = pc_q;
    assign misaligned  = mis_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_ready = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_pc = '0;
    logic        ras_push = 1'b0;
    logic [31:0] ras_push_addr = '0;
    logic        ras_pop = 1'b0;
    logic        halt_req = 1'b0;

    logic        fv1, mis1, hlt1;
    logic [31:0] pc1;
    logic        fv2, mis2, hlt2;
    logic [31:0] pc2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pc_gen #(.XLEN(32), .START_ADDR(32'h100), .IALIGN(4), .RAS_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .fetch_valid(fv1), .fetch_ready(fetch_ready), .fetch_pc(pc1),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .trap_valid(trap_valid), .trap_pc(trap_pc), .ras_push(ras_push),
        .ras_push_addr(ras_push_addr), .ras_pop(ras_pop), .halt_req(halt_req),
        .misaligned(mis1), .halted(hlt1)
    );

    pc_gen #(.XLEN(32), .START_ADDR(32'h100), .IALIGN(2), .RAS_DEPTH(4)) dut2 (
        .clk(clk), .rst(rst), .fetch_valid(fv2), .fetch_ready(fetch_ready), .fetch_pc(pc2),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .trap_valid(trap_valid), .trap_pc(trap_pc), .ras_push(ras_push),
        .ras_push_addr(ras_push_addr), .ras_pop(ras_pop), .halt_req(halt_req),
        .misaligned(mis2), .halted(hlt2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        fetch_ready = 1'b1;
        tick();
        tick();
        checks++; if (pc1 !== 32'h100) begin errors++; $display("FAIL reset_pc: got %h want %h", pc1, 32'h100); end
        checks++; if (fv1 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", fv1); end
        checks++; if (hlt1 !== 1'b0 || mis1 !== 1'b0) begin errors++; $display("FAIL reset_flags: got halted=%b mis=%b want 0 0", hlt1, mis1); end
        checks++; if (pc2 !== 32'h100 || fv2 !== 1'b0 || hlt2 !== 1'b0 || mis2 !== 1'b0) begin errors++; $display("FAIL reset_dut2: got pc=%h v=%b h=%b m=%b want 100 0 0 0", pc2, fv2, hlt2, mis2); end
    endtask

    task automatic test_sequential();
        rst = 1'b1;
        tick();
        checks++; if (fv1 !== 1'b1 || pc1 !== 32'h100) begin errors++; $display("FAIL first_fetch: got v=%b pc=%h want 1 100", fv1, pc1); end
        tick();
        checks++; if (pc1 !== 32'h104) begin errors++; $display("FAIL seq_1: got %h want %h", pc1, 32'h104); end
        tick();
        checks++; if (pc1 !== 32'h108) begin errors++; $display("FAIL seq_2: got %h want %h", pc1, 32'h108); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (pc1 !== 32'h108) begin errors++; $display("FAIL stall_hold[%0d]: got %h want %h", i, pc1, 32'h108); end
        end
        stall = 1'b0;
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (pc1 !== 32'h108 || fv1 !== 1'b1) begin errors++; $display("FAIL notready_hold[%0d]: got pc=%h v=%b want 108 1", i, pc1, fv1); end
        end
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h2000;
        tick();
        checks++; if (pc1 !== 32'h2000) begin errors++; $display("FAIL redirect_in_stall: got %h want %h", pc1, 32'h2000); end
        redirect_valid = 1'b0;
        stall = 1'b0;
        fetch_ready = 1'b1;
    endtask

    task automatic test_trap();
        ras_push = 1'b1;
        ras_push_addr = 32'h10;
        tick();
        checks++; if (pc1 !== 32'h2004) begin errors++; $display("FAIL push_seq: got %h want %h", pc1, 32'h2004); end
        ras_push = 1'b0;
        trap_valid = 1'b1;
        trap_pc = 32'h8000_0003;
        redirect_valid = 1'b1;
        redirect_pc = 32'h400;
        tick();
        checks++; if (pc1 !== 32'h8000_0000) begin errors++; $display("FAIL trap_prio: got %h want %h", pc1, 32'h8000_0000); end
        checks++; if (mis1 !== 1'b0) begin errors++; $display("FAIL trap_no_mis: got %b want 0", mis1); end
        trap_valid = 1'b0;
        redirect_valid = 1'b0;
        ras_pop = 1'b1;
        tick();
        checks++; if (pc1 !== 32'h8000_0004) begin errors++; $display("FAIL trap_clears_ras: got %h want %h", pc1, 32'h8000_0004); end
        ras_pop = 1'b0;
    endtask

    task automatic test_misaligned();
        trap_valid = 1'b1;
        trap_pc = 32'h3000;
        tick();
        trap_valid = 1'b0;
        checks++; if (pc1 !== 32'h3000 || pc2 !== 32'h3000) begin errors++; $display("FAIL mis_setup: got %h/%h want 3000/3000", pc1, pc2); end
        redirect_valid = 1'b1;
        redirect_pc = 32'h402;
        tick();
        redirect_valid = 1'b0;
        checks++; if (pc1 !== 32'h3000 || mis1 !== 1'b1) begin errors++; $display("FAIL mis_ialign4: got pc=%h mis=%b want 3000 1", pc1, mis1); end
        checks++; if (pc2 !== 32'h402 || mis2 !== 1'b0) begin errors++; $display("FAIL mis_ialign2: got pc=%h mis=%b want 402 0", pc2, mis2); end
        tick();
        checks++; if (mis1 !== 1'b0 || pc1 !== 32'h3004) begin errors++; $display("FAIL mis_pulse_end: got mis=%b pc=%h want 0 3004", mis1, pc1); end
        checks++; if (pc2 !== 32'h404) begin errors++; $display("FAIL ialign2_step: got %h want %h", pc2, 32'h404); end
    endtask

    task automatic test_ras();
        logic [31:0] exp_pc;
        logic [31:0] pred [5];
        pred[0] = 32'h50; pred[1] = 32'h40; pred[2] = 32'h30; pred[3] = 32'h20; pred[4] = 32'h24;
        exp_pc = 32'h3004;
        ras_push = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            ras_push_addr = 32'(i * 16);
            tick();
            exp_pc = exp_pc + 32'h4;
            checks++; if (pc1 !== exp_pc) begin errors++; $display("FAIL ras_push_seq[%0d]: got %h want %h", i, pc1, exp_pc); end
        end
        ras_push = 1'b0;
        ras_pop = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (pc1 !== pred[i]) begin errors++; $display("FAIL ras_pop[%0d]: got %h want %h", i, pc1, pred[i]); end
        end
        ras_pop = 1'b0;
        ras_push = 1'b1;
        ras_push_addr = 32'h60;
        tick();
        checks++; if (pc1 !== 32'h28) begin errors++; $display("FAIL ras_push60: got %h want %h", pc1, 32'h28); end
        ras_pop = 1'b1;
        ras_push_addr = 32'h70;
        tick();
        checks++; if (pc1 !== 32'h60) begin errors++; $display("FAIL ras_pushpop_pred: got %h want %h", pc1, 32'h60); end
        ras_push = 1'b0;
        tick();
        checks++; if (pc1 !== 32'h70) begin errors++; $display("FAIL ras_pushpop_replace: got %h want %h", pc1, 32'h70); end
        tick();
        checks++; if (pc1 !== 32'h74) begin errors++; $display("FAIL ras_empty_after: got %h want %h", pc1, 32'h74); end
        ras_pop = 1'b0;
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        checks++; if (pc1 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup: got %h want %h", pc1, 32'hFFFF_FFFC); end
        tick();
        checks++; if (pc1 !== 32'h0) begin errors++; $display("FAIL wrap: got %h want 0", pc1); end
    endtask

    task automatic test_halt();
        halt_req = 1'b1;
        tick();
        checks++; if (fv1 !== 1'b0 || hlt1 !== 1'b1 || pc1 !== 32'h4) begin errors++; $display("FAIL halt_enter: got v=%b h=%b pc=%h want 0 1 4", fv1, hlt1, pc1); end
        tick();
        checks++; if (fv1 !== 1'b0 || hlt1 !== 1'b1 || pc1 !== 32'h4) begin errors++; $display("FAIL halt_hold: got v=%b h=%b pc=%h want 0 1 4", fv1, hlt1, pc1); end
        halt_req = 1'b0;
        tick();
        checks++; if (fv1 !== 1'b1 || hlt1 !== 1'b0 || pc1 !== 32'h4) begin errors++; $display("FAIL halt_exit: got v=%b h=%b pc=%h want 1 0 4", fv1, hlt1, pc1); end
        tick();
        checks++; if (pc1 !== 32'h8) begin errors++; $display("FAIL halt_resume: got %h want %h", pc1, 32'h8); end
        halt_req = 1'b1;
        tick();
        checks++; if (hlt1 !== 1'b1 || pc1 !== 32'hC) begin errors++; $display("FAIL halt_again: got h=%b pc=%h want 1 c", hlt1, pc1); end
        trap_valid = 1'b1;
        trap_pc = 32'h500;
        tick();
        trap_valid = 1'b0;
        halt_req = 1'b0;
        checks++; if (hlt1 !== 1'b0 || fv1 !== 1'b1 || pc1 !== 32'h500) begin errors++; $display("FAIL trap_in_halt: got h=%b v=%b pc=%h want 0 1 500", hlt1, fv1, pc1); end
        tick();
        checks++; if (pc1 !== 32'h504) begin errors++; $display("FAIL trap_halt_run: got %h want %h", pc1, 32'h504); end
    endtask

    task automatic test_async_reset();
        #2;
        rst = 1'b0;
        #1;
        checks++; if (pc1 !== 32'h100 || fv1 !== 1'b0 || hlt1 !== 1'b0) begin errors++; $display("FAIL async_reset: got pc=%h v=%b h=%b want 100 0 0", pc1, fv1, hlt1); end
        tick();
        rst = 1'b1;
        tick();
        checks++; if (pc1 !== 32'h100 || fv1 !== 1'b1) begin errors++; $display("FAIL reset_restart: got pc=%h v=%b want 100 1", pc1, fv1); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_trap();
        test_misaligned();
        test_ras();
        test_wrap();
        test_halt();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage, replacing the bare PC register with one that computes the sequential next PC internally. It arbitrates trap, branch/jump redirect and return-address-stack (RAS) prediction, and presents the current fetch address over a valid/ready handshake. It also supports stall, debug halt and misaligned-target detection, and sits between the CSR/execute redirect sources and the instruction memory port.

## Interface
- XLEN, 32, address width
- START_ADDR, 32'h00000000, PC value after reset
- IALIGN, 4, instruction alignment in bytes, 2 or 4; sequential increment equals IALIGN
- RAS_DEPTH, 4, return-address-stack entries, power of two, ≥2
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- fetch_valid  out  1  fetch_pc is a valid fetch request
- fetch_ready  in  1  instruction memory accepts request
- fetch_pc  out  XLEN  current fetch address
- stall  in  1  hazard hold; blocks sequential advance and RAS ops
- redirect_valid  in  1  branch/jump resolved to redirect_pc
- redirect_pc  in  XLEN  redirect target
- trap_valid  in  1  trap/interrupt entry or return
- trap_pc  in  XLEN  trap target from CSR unit
- ras_push  in  1  call decoded on current fetch
- ras_push_addr  in  XLEN  return address to push
- ras_pop  in  1  return decoded on current fetch; predict top of stack
- halt_req  in  1  debug halt request (level)
- misaligned  out  1  one-cycle pulse: redirect target not IALIGN-aligned
- halted  out  1  block is in HALTED state

## Operation
- States: BOOT, RUN, HALTED.
  - BOOT → RUN unconditionally after one cycle.
  - RUN → HALTED when halt_req and no trap/redirect in that cycle.
  - HALTED → RUN when halt_req deasserts.
  - trap_valid in any state forces RUN.
- fetch_valid = 1 only in RUN.
- fire = fetch_valid & fetch_ready & !stall.
- Next-PC priority, highest first:
  1. trap_valid → trap_pc with low log2(IALIGN) bits cleared.
  2. redirect_valid, aligned → redirect_pc.
  3. redirect_valid, misaligned → PC held; misaligned pulses next cycle.
  4. fire & ras_pop & RAS non-empty → RAS top.
  5. fire → fetch_pc + IALIGN, modulo 2^XLEN (wraps to 0).
  6. Otherwise hold.
- Trap and redirect act regardless of stall, fetch_ready or HALTED.
- RAS: circular buffer with pointer and count (0..RAS_DEPTH).
  - Ops are applied only on fire with no trap/redirect in the same cycle.
  - push: write at ptr+1, ptr++, count saturates at RAS_DEPTH. Push when full overwrites the oldest entry.
  - pop: ptr--, count--. Pop when empty is ignored; next PC is sequential.
  - push & pop together: top entry replaced with ras_push_addr; ptr and count unchanged. Prediction uses the old top.
  - trap_valid clears the RAS (count=0, ptr=0).
- Reset values: fetch_pc=START_ADDR, fetch_valid=0, misaligned=0, halted=0, state=BOOT, RAS count=0, ptr=0. Entry contents are don't-care.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- The first valid fetch of START_ADDR occurs in the cycle after the first clk edge following reset release.
- Redirect/trap latency: target appears on fetch_pc one cycle after the input is sampled.
- fetch_pc holds stable while fetch_valid & !fetch_ready.
- Reset asserted mid-operation returns all state to reset values immediately, asynchronously.

## Structure
- Package pc_pkg:
  - pc_state_t enum (BOOT, RUN, HALTED).
  - next_sel_t enum (SEL_TRAP, SEL_REDIR, SEL_RAS, SEL_SEQ, SEL_HOLD).
- Sub-module pc_ras holds the stack storage, pointer, count, push/pop/clear logic, top-of-stack output and empty flag.
- pc_gen contains the FSM, the next-PC mux and the alignment check.

## Test plan
- Reset release with fetch_ready=1, START_ADDR=0x100, IALIGN=4 → fetch_valid rises one cycle after release; fetch_pc steps 0x100, 0x104, 0x108.
- Stall and fetch_ready=0 each held 3 cycles → fetch_pc held. Same-cycle redirect to 0x2000 → next fetch_pc=0x2000.
- Same cycle trap_pc=0x80000003 and redirect_pc=0x400 → fetch_pc=0x80000000; RAS count becomes 0.
- Redirect to 0x402 with IALIGN=4 → misaligned pulses once; fetch_pc unchanged. Same target with IALIGN=2 → accepted.
- RAS_DEPTH=4: push 0x10, 0x20, 0x30, 0x40, 0x50, then pop five times → predicted PCs 0x50, 0x40, 0x30, 0x20; fifth pop (stack empty) → sequential PC.
- fetch_pc=0xFFFFFFFC with fire → next fetch_pc=0x0. halt_req for 2 cycles → fetch_valid=0, halted=1, PC held; RUN resumes at the held PC.
